// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the dual-channel button event generator.
// Holds the channel FSM state encoding and the counter width function.
package btn_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } btn_state_t;

  function automatic int cnt_width(input int long_c, input int rpt_c);
    int m;
    m = (long_c > rpt_c) ? long_c : rpt_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_event_ch.sv
// One button channel: edge detect plus press/long/repeat FSM.
// All pulse outputs are registered and at most one is high per cycle.
module btn_event_ch
  import btn_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press,
  output logic rel,
  output logic long,
  output logic rpt
);

  localparam int CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] LONG_T = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] RPT_T  = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  btn_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic          prev_q;
  logic          press_q;
  logic          rel_q;
  logic          long_q;
  logic          rpt_q;
  logic          rise;
  logic          fall;

  assign rise = btn_in & ~prev_q;
  assign fall = ~btn_in & prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      prev_q  <= btn_in;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            press_q <= 1'b1;
            cnt_q   <= ONE;
            state_q <= PRESSED;
          end else begin
            cnt_q <= '0;
          end
        end
        PRESSED: begin
          // release wins over a long-press on the same edge
          if (fall) begin
            rel_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == LONG_T) begin
            long_q  <= 1'b1;
            cnt_q   <= ONE;
            state_q <= HELD;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        HELD: begin
          if (fall) begin
            rel_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == RPT_T) begin
            rpt_q <= 1'b1;
            cnt_q <= ONE;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign press = press_q;
  assign rel   = rel_q;
  assign long  = long_q;
  assign rpt   = rpt_q;

endmodule

// File: rtl/btn_event.sv
// Dual-channel button event generator.
// Two independent channel instances wired straight through.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in_1,
  input  logic btn_in_2,
  output logic press_1,
  output logic press_2,
  output logic rel_1,
  output logic rel_2,
  output logic long_1,
  output logic long_2,
  output logic rpt_1,
  output logic rpt_2
);

  btn_event_ch #(
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_in_1),
    .press (press_1),
    .rel   (rel_1),
    .long  (long_1),
    .rpt   (rpt_1)
  );

  btn_event_ch #(
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_ch2 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_in_2),
    .press (press_2),
    .rel   (rel_2),
    .long  (long_2),
    .rpt   (rpt_2)
  );

endmodule

// File: tb/tb_btn_event.sv
// Directed and random-level bench for btn_event (LONG=8, REPEAT=3).
// Edge numbers count from the first rising edge after reset release.
module tb_btn_event;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in_1 = 1'b0;
  logic btn_in_2 = 1'b0;
  logic press_1, press_2, rel_1, rel_2;
  logic long_1, long_2, rpt_1, rpt_2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  btn_event #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_in_1(btn_in_1),
    .btn_in_2(btn_in_2),
    .press_1 (press_1),
    .press_2 (press_2),
    .rel_1   (rel_1),
    .rel_2   (rel_2),
    .long_1  (long_1),
    .long_2  (long_2),
    .rpt_1   (rpt_1),
    .rpt_2   (rpt_2)
  );

  wire [3:0] o1 = {press_1, rel_1, long_1, rpt_1};
  wire [3:0] o2 = {press_2, rel_2, long_2, rpt_2};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit lvl(input int e, input int r, input int f);
    return (r != 0) && (e >= r) && (f == 0 || e < f);
  endfunction

  // r*/f*: rise/fall edges (0 = never); p/q/l/a/b: expected press,
  // rel, long, rpt edges (0 = none). Ends at a falling clock edge.
  task automatic run(input string nm, input bit rst,
                     input int r1, input int f1,
                     input int r2, input int f2, input int n,
                     input int p1, input int q1, input int l1,
                     input int a1, input int b1,
                     input int p2, input int q2, input int l2);
    logic [3:0] e1, e2;
    if (rst) begin
      rst_n    = 1'b0;
      btn_in_1 = 1'b0;
      btn_in_2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk($sformatf("%s rst", nm), {24'd0, o1, o2}, 32'd0);
    end
    for (int e = 1; e <= n; e++) begin
      btn_in_1 = lvl(e, r1, f1);
      btn_in_2 = lvl(e, r2, f2);
      @(posedge clk);
      #1;
      e1 = {e == p1, e == q1, e == l1, (e == a1) || (e == b1)};
      e2 = {e == p2, e == q2, e == l2, 1'b0};
      chk($sformatf("%s ch1 e%0d", nm, e), {28'd0, o1}, {28'd0, e1});
      chk($sformatf("%s ch2 e%0d", nm, e), {28'd0, o2}, {28'd0, e2});
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] pv1, pv2;

    run("short", 1, 10, 15, 0, 0, 30,
        10, 15, 0, 0, 0, 0, 0, 0);
    run("long", 1, 10, 25, 0, 0, 35,
        10, 25, 18, 21, 24, 0, 0, 0);
    run("term", 1, 10, 18, 0, 0, 30,
        10, 18, 0, 0, 0, 0, 0, 0);
    run("dual", 1, 5, 0, 5, 9, 20,
        5, 0, 13, 16, 19, 5, 9, 0);

    run("midrst", 1, 10, 0, 0, 0, 20,
        10, 0, 18, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst drop", {24'd0, o1, o2}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst hold%0d", i), {24'd0, o1, o2}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run("afterrst", 0, 1, 0, 0, 0, 13,
        1, 0, 9, 12, 0, 0, 0, 0);

    run("rnd", 1, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0);
    pv1 = '0;
    pv2 = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(15) == 0) btn_in_1 = ~btn_in_1;
      if ($urandom_range(15) == 0) btn_in_2 = ~btn_in_2;
      @(posedge clk);
      #1;
      chk("excl1", {31'd0, $onehot0(o1)}, 32'd1);
      chk("excl2", {31'd0, $onehot0(o2)}, 32'd1);
      chk("width1", {28'd0, o1 & pv1}, 32'd0);
      chk("width2", {28'd0, o2 & pv2}, 32'd0);
      pv1 = o1;
      pv2 = o2;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/btn_event.md
# btn_event

Dual-channel button event generator. It sits directly downstream of the dual debouncer and consumes its two stable button levels. For each channel it produces single-cycle pulses for press, release, long-press and auto-repeat. Control FSMs (counters, menu steppers) use these pulses as clean, one-clock-wide commands.

## Interface

Parameters:
- `LONG_CYCLES`, default 50_000_000: cycles from the press pulse to the long-press pulse (0.5 s at 100 MHz). Legal range is ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: cycles between consecutive auto-repeat pulses after long-press. Legal range is ≥ 1.

Ports:
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn_in_1`, input, 1: debounced level, channel 1. 1 means pressed.
- `btn_in_2`, input, 1: debounced level, channel 2.
- `press_1` / `press_2`, output, 1 each: one-cycle pulse on a press.
- `rel_1` / `rel_2`, output, 1 each: one-cycle pulse on a release.
- `long_1` / `long_2`, output, 1 each: one-cycle pulse when a hold reaches `LONG_CYCLES`.
- `rpt_1` / `rpt_2`, output, 1 each: one-cycle auto-repeat pulse while held after long-press.

## Operation

- The two channels are fully independent. Each is an identical instance with no shared state.
- Each channel has:
  - a previous-level register `prev`
  - a cycle counter `cnt`, of width `$clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1)`
  - a 3-state FSM: IDLE, PRESSED, HELD
- Rise = `btn_in & ~prev`. Fall = `~btn_in & prev`. `prev <= btn_in` every edge.
- IDLE:
  - On rise: assert press, set `cnt <= 1`, go to PRESSED.
  - Otherwise stay in IDLE with `cnt` held at 0.
- PRESSED:
  - On fall: assert rel, go to IDLE, set `cnt <= 0`.
  - Else if `cnt == LONG_CYCLES`: assert long, set `cnt <= 1`, go to HELD.
  - Else `cnt <= cnt + 1`.
- HELD:
  - On fall: assert rel, go to IDLE, set `cnt <= 0`.
  - Else if `cnt == REPEAT_CYCLES`: assert rpt, set `cnt <= 1`.
  - Else `cnt <= cnt + 1`.
- Fall has priority over long and rpt on the same edge. A release on the exact terminal edge yields rel only.
- Pulses are mutually exclusive per channel. At most one of press/rel/long/rpt is high in any cycle.
- `cnt` never exceeds its terminal value. There is no wrap-around beyond the reload to 1.
- All outputs are registered. There are no combinational paths from `btn_in_*` to outputs.

## Timing

- Reset value of every output is 0. Reset also forces FSM = IDLE, `cnt` = 0, `prev` = 0.
- Reset takes effect asynchronously. Release of `rst_n` is used synchronously: the first active edge after deassertion is a normal edge.
- Latency:
  - A rise sampled at edge k produces press high during the cycle after edge k. The same holds for fall and rel.
  - long is high after edge k + `LONG_CYCLES`.
  - The n-th rpt is high after edge k + `LONG_CYCLES` + n·`REPEAT_CYCLES`.
- Every pulse is exactly one clock wide.
- Level held high through reset deassertion: `prev` = 0, so a press is generated at the first edge after reset. This is intended.
- Reset asserted mid-hold: outputs drop to 0 immediately and no rel is emitted.
- Input is trusted to be debounced. A one-cycle glitch yields a press/rel pair on consecutive edges and is legal.

## Structure

- Shared package `btn_event_pkg`:
  - state enum `btn_state_t` {IDLE, PRESSED, HELD}
  - function `cnt_width(long, repeat)` returning the counter width
- One sub-module, `btn_event_ch`: a single channel with the same parameters, `clk`, `rst_n`, `btn_in`, and press/rel/long/rpt.
- The top instantiates `btn_event_ch` twice and wires the ports straight through.

## Test plan

Bench runs with `LONG_CYCLES` = 8 and `REPEAT_CYCLES` = 3. Edge numbers count from the first edge after reset release.

- **Short press:** `btn_in_1` rises, sampled at edge 10, and falls at edge 15 → press_1 after 10, rel_1 after 15, no long_1/rpt_1, channel 2 all 0.
- **Long hold with repeat:** rise at edge 10, fall at edge 25 → press_1 @10, long_1 @18, rpt_1 @21 and @24, rel_1 @25, nothing else.
- **Terminal-edge release:** rise at edge 10, fall at edge 18 → press_1 @10, rel_1 @18, long_1 never asserted.
- **Simultaneous channels:** both inputs rise at edge 5; `btn_in_2` falls at edge 9 while `btn_in_1` is held → press_1/press_2 @5, rel_2 @9, long_1 @13, no long_2.
- **Reset mid-hold:** assert `rst_n` = 0 at edge 20 of a hold that rose at edge 10 → all outputs 0 immediately and no rel. Deassert with the input still high → press one edge later, long 8 edges after that.
- **Pulse exclusivity:** random level stimulus for 10k cycles → assertion that at most one of each channel's four outputs is high per cycle, and every pulse is exactly 1 cycle wide.
